// File: rtl/audio_sample_fetch.sv
// ---------------------------------------------------------------------------
// audio_sample_fetch
//
// Sequencer that reads audio samples from a synchronous sample memory and
// hands them to a PWM converter. Each sample period is TICK_DIV clk cycles.
// One memory read is issued per period. The returned word is captured into
// sample_o with a valid/ready handshake.
//
// Parameters
//   ADDR_W   : sample-memory address width
//   DATA_W   : sample width
//   TICK_DIV : clk cycles between consecutive reads. The legal range is
//              4..65535.
//
// Ports
//   clk, rst       : single clock; asynchronous active-high reset
//   play           : start playback from address 0 (ignored while busy)
//   stop           : abort playback; wins over play
//   loop_en        : at end_addr, wrap to 0 instead of finishing
//   end_addr       : last sample address (inclusive); latched with play
//   rom_addr       : memory read address
//   rom_rd_en      : one-cycle read strobe
//   rom_data       : read data, valid the cycle after rom_rd_en
//   sample_o       : sample presented to the PWM stage
//   sample_valid   : sample_o holds an unconsumed sample
//   sample_ready   : downstream consumes sample_o this cycle
//   busy           : sequencer is not idle
//   done           : one-cycle pulse when a non-looping playback completes
//   overrun        : sticky; a sample was overwritten before being consumed
// ---------------------------------------------------------------------------
module audio_sample_fetch #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TICK_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // READ and LATCH take one cycle each.
  // The rest of the sample period is spent in WAIT. The counter is
  // cleared in READ and advances in LATCH and WAIT. When it reaches
  // TICK_DIV-2, the next READ lands exactly TICK_DIV cycles after the
  // previous one.
  localparam logic [15:0] WAIT_LAST = 16'(TICK_DIV - 2);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] end_lat;
  logic [15:0]       tick_cnt;

  logic accept_play;
  logic capture;
  logic at_end;
  logic finish;

  assign accept_play = (state == IDLE) && play && !stop;
  // A LATCH cycle with stop asserted discards the in-flight read.
  assign capture     = (state == LATCH) && !stop;
  assign at_end      = (rom_addr == end_lat);
  assign finish      = capture && at_end && !loop_en;

  assign rom_rd_en   = (state == READ);
  assign busy        = (state != IDLE);
  assign done        = finish;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_play) state_nxt = READ;
      end
      READ: begin
        state_nxt = stop ? IDLE : LATCH;
      end
      LATCH: begin
        if (stop || finish) state_nxt = IDLE;
        else                state_nxt = WAIT;
      end
      WAIT: begin
        if (stop)                       state_nxt = IDLE;
        else if (tick_cnt == WAIT_LAST) state_nxt = READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address sequencing and latched end address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      end_lat  <= '0;
    end else if (accept_play) begin
      rom_addr <= '0;
      end_lat  <= end_addr;
    end else if (capture && !finish) begin
      // On completion the address is left where it is. It is only
      // reused after the next accepted play, which resets it to 0.
      rom_addr <= at_end ? '0 : rom_addr + ADDR_W'(1);
    end
  end

  // Sample-period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else begin
      case (state)
        READ:        tick_cnt <= '0;
        LATCH, WAIT: tick_cnt <= tick_cnt + 16'd1;
        default:     tick_cnt <= tick_cnt;
      endcase
    end
  end

  // Output sample register and handshake. A reload in the same cycle
  // as a consume keeps valid high, so the new sample is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_o     <= '0;
      sample_valid <= 1'b0;
    end else if (capture) begin
      sample_o     <= rom_data;
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky overrun. It is cleared only when a new playback starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (accept_play) begin
      overrun <= 1'b0;
    end else if (capture && sample_valid && !sample_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_fetch.sv
module tb_audio_sample_fetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TD     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              play;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd_en;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid;
  logic              sample_ready;
  logic              busy;
  logic              done;
  logic              overrun;

  audio_sample_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .loop_en(loop_en),
    .end_addr(end_addr), .rom_addr(rom_addr), .rom_rd_en(rom_rd_en),
    .rom_data(rom_data), .sample_o(sample_o), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Sample memory: ROM[a] = a + 0x100, one cycle read latency
  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= DATA_W'(rom_addr) + 32'h100;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int                exp_rd_cyc[$];
  logic [ADDR_W-1:0] exp_rd_addr[$];
  logic [DATA_W-1:0] exp_smp[$];
  int                exp_done[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d, expected none", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick(1);
  endtask

  // Reference model of one playback started at cycle c.
  // Reads fall every TD cycles from c+1, and addresses walk 0..e
  // cyclically. The first nsmp fetched samples are expected to be
  // consumed. A non-looping full run ends with done in the LATCH cycle
  // of the last fetch.
  task automatic push_run(input int c, input int e, input int nfetch,
                          input int nsmp, input bit exp_done_pulse);
    for (int k = 0; k < nfetch; k++) begin
      exp_rd_cyc.push_back(c + 1 + k * TD);
      exp_rd_addr.push_back(ADDR_W'(k % (e + 1)));
      if (k < nsmp) exp_smp.push_back(DATA_W'(k % (e + 1)) + 32'h100);
    end
    if (exp_done_pulse) exp_done.push_back(c + 2 + e * TD);
  endtask

  task automatic start_play(input int e, input bit l, output int c);
    loop_en  = l;
    end_addr = ADDR_W'(e);
    play     = 1'b1;
    c        = cyc;
    tick(1);
    play     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"},  64'(rom_addr),     64'd0);
    chk({tag, "_rd_en"},     64'(rom_rd_en),    64'd0);
    chk({tag, "_sample_o"},  64'(sample_o),     64'd0);
    chk({tag, "_valid"},     64'(sample_valid), 64'd0);
    chk({tag, "_busy"},      64'(busy),         64'd0);
    chk({tag, "_done"},      64'(done),         64'd0);
    chk({tag, "_overrun"},   64'(overrun),      64'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_rd_en) begin
        if (exp_rd_cyc.size() == 0) unexpected("rd_en");
        else begin
          chk("rd_cycle", 64'(cyc), 64'(exp_rd_cyc.pop_front()));
          chk("rd_addr", 64'(rom_addr), 64'(exp_rd_addr.pop_front()));
        end
      end
      if (sample_valid && sample_ready) begin
        if (exp_smp.size() == 0) unexpected("sample");
        else chk("sample", 64'(sample_o), 64'(exp_smp.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done");
        else chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int e;
    int n;
    rst = 1'b1; play = 1'b0; stop = 1'b0; loop_en = 1'b0;
    end_addr = '0; sample_ready = 1'b1;
    #2;
    chk_all_zero("reset");
    tick(2);
    rst = 1'b0;
    tick(2);

    // Basic run, end=3, with a play pulse while busy that must be ignored
    start_play(3, 1'b0, c);
    push_run(c, 3, 4, 4, 1'b1);
    wait_to(c + 5);
    end_addr = 32'd7; play = 1'b1;
    tick(1);
    play = 1'b0; end_addr = 32'd3;
    wait_to(c + 26);
    chk("basic_busy_26", 64'(busy), 64'd1);
    wait_to(c + 27);
    chk("basic_busy_27", 64'(busy), 64'd0);
    tick(3);

    // Looping, end=1: addresses 0,1,0,1,... with no done
    start_play(1, 1'b1, c);
    push_run(c, 1, 6, 6, 1'b0);
    wait_to(c + 44);
    chk("loop_busy", 64'(busy), 64'd1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("loop_stop_busy", 64'(busy), 64'd0);
    loop_en = 1'b0;
    tick(3);

    // Overrun: downstream never ready
    sample_ready = 1'b0;
    start_play(3, 1'b0, c);
    push_run(c, 3, 2, 0, 1'b0);
    wait_to(c + 3);
    chk("ovr_first", 64'(overrun), 64'd0);
    wait_to(c + 11);
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_sample", 64'(sample_o), 64'h101);
    chk("ovr_valid", 64'(sample_valid), 64'd1);
    wait_to(c + 12);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("ovr_stop_busy", 64'(busy), 64'd0);
    chk("ovr_stop_valid", 64'(sample_valid), 64'd1);
    chk("ovr_stop_sample", 64'(sample_o), 64'h101);
    exp_smp.push_back(32'h101);
    sample_ready = 1'b1;
    tick(1);
    chk("ovr_drained", 64'(sample_valid), 64'd0);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // play and stop together in IDLE: stop wins
    play = 1'b1; stop = 1'b1;
    tick(1);
    play = 1'b0; stop = 1'b0;
    chk("playstop_busy", 64'(busy), 64'd0);

    // end=0 single sample; play clears overrun
    start_play(0, 1'b0, c);
    push_run(c, 0, 1, 1, 1'b1);
    chk("ovr_cleared", 64'(overrun), 64'd0);
    wait_to(c + 3);
    chk("single_busy", 64'(busy), 64'd0);
    tick(2);

    // stop in the READ cycle of fetch #2
    start_play(3, 1'b0, c);
    push_run(c, 3, 2, 1, 1'b0);
    wait_to(c + 9);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stopread_busy", 64'(busy), 64'd0);
    chk("stopread_done", 64'(done), 64'd0);
    chk("stopread_sample", 64'(sample_o), 64'h100);
    tick(2);
    chk("stopread_sample_hold", 64'(sample_o), 64'h100);

    // reset pulse during WAIT, then restart from address 0
    start_play(3, 1'b0, c);
    push_run(c, 3, 1, 1, 1'b0);
    wait_to(c + 5);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick(1);
    rst = 1'b0;
    tick(1);
    start_play(2, 1'b0, c);
    push_run(c, 2, 3, 3, 1'b1);
    wait_to(c + 2 + 2 * TD + 1);
    chk("restart_busy", 64'(busy), 64'd0);
    tick(2);

    // play held high across completion: restart the cycle after IDLE
    c = cyc;
    loop_en = 1'b0; end_addr = 32'd1; play = 1'b1;
    push_run(c, 1, 2, 2, 1'b1);
    push_run(c + 11, 1, 2, 2, 1'b1);
    wait_to(c + 11);
    chk("held_idle", 64'(busy), 64'd0);
    wait_to(c + 13);
    play = 1'b0;
    wait_to(c + 23);
    chk("held_end_busy", 64'(busy), 64'd0);
    tick(2);

    // randomized non-looping runs
    for (int i = 0; i < 4; i++) begin
      e = int'($urandom_range(0, 5));
      start_play(e, 1'b0, c);
      push_run(c, e, e + 1, e + 1, 1'b1);
      wait_to(c + 1 + e * TD + 3);
      chk("rand_busy", 64'(busy), 64'd0);
      tick(int'($urandom_range(0, 3)));
    end

    // randomized looping runs terminated by stop
    for (int i = 0; i < 2; i++) begin
      e = int'($urandom_range(0, 3));
      n = int'($urandom_range(e + 2, 8));
      start_play(e, 1'b1, c);
      push_run(c, e, n, n, 1'b0);
      wait_to(c + 1 + (n - 1) * TD + 4);
      chk("rand_loop_busy", 64'(busy), 64'd1);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("rand_loop_stop", 64'(busy), 64'd0);
      loop_en = 1'b0;
      tick(2);
    end

    tick(4);
    chk("rd_left", 64'(exp_rd_cyc.size()), 64'd0);
    chk("smp_left", 64'(exp_smp.size()), 64'd0);
    chk("done_left", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_sample_fetch.md
AUDIO_SAMPLE_FETCH -- requirements
Module: audio_sample_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32; sample-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32; sample width, matching the 32-bit PWM converter input.
REQ-003 SHALL have parameter TICK_DIV, default 1024; clk cycles per sample period; legal range 4..65535.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port play  in  1  start playback from address 0 (level-sampled).
REQ-007 SHALL have port stop  in  1  abort playback (level-sampled).
REQ-008 SHALL have port loop_en  in  1  at end address, wrap to 0 instead of finishing.
REQ-009 SHALL have port end_addr  in  ADDR_W  last sample address (inclusive); sampled when play is accepted.
REQ-010 SHALL have port rom_addr  out  ADDR_W  sample-memory read address.
REQ-011 SHALL have port rom_rd_en  out  1  read strobe; one cycle per fetch.
REQ-012 SHALL have port rom_data  in  DATA_W  read data, valid exactly 1 cycle after rom_rd_en.
REQ-013 SHALL have port sample_o  out  DATA_W  sample for the PWM stage.
REQ-014 SHALL have port sample_valid  out  1  sample_o holds an unconsumed sample.
REQ-015 SHALL have port sample_ready  in  1  downstream accepts sample_o this cycle.
REQ-016 SHALL have port busy  out  1  high in any state except IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse on non-loop completion.
REQ-018 SHALL have port overrun  out  1  sticky: a sample overwrote an unconsumed one.

Function
REQ-019 SHALL implement FSM states IDLE, READ, LATCH, WAIT.
REQ-020 IDLE: play=1 and stop=0 SHALL latch end_addr, set rom_addr=0, clear overrun, and go to READ.
REQ-021 READ SHALL assert rom_rd_en for exactly one cycle, clear the tick counter, and go to LATCH.
REQ-022 LATCH SHALL load sample_o<=rom_data and set sample_valid=1; if sample_valid=1 and sample_ready=0 in that cycle, overrun SHALL be set.
REQ-023 LATCH with rom_addr≠latched end: rom_addr SHALL increment by 1 and the FSM SHALL go to WAIT.
REQ-024 LATCH with rom_addr=latched end and loop_en=1: rom_addr SHALL be set to 0 and the FSM SHALL go to WAIT.
REQ-025 LATCH with rom_addr=latched end and loop_en=0: done SHALL pulse and the FSM SHALL go to IDLE.
REQ-026 WAIT SHALL count clk cycles and enter READ so that consecutive rom_rd_en pulses are exactly TICK_DIV cycles apart.
REQ-027 Latency: with play accepted at cycle N, rom_rd_en SHALL be high at N+1 and sample_valid SHALL rise at N+3.
REQ-028 sample_valid SHALL clear on the cycle after sample_valid=1 and sample_ready=1, unless LATCH reloads in that same cycle, in which case it SHALL stay 1 with the new sample.
REQ-029 stop=1 in any non-IDLE state SHALL force IDLE next cycle with no capture and no done pulse; an in-flight read SHALL be discarded.
REQ-030 sample_o and sample_valid SHALL be unaffected by stop; a pending sample SHALL remain until consumed.
REQ-031 play asserted while busy SHALL be ignored; play and stop together in IDLE SHALL be ignored (stop wins).
REQ-032 rom_addr arithmetic SHALL be ADDR_W-bit modulo; end_addr=0 SHALL play a single sample.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, rom_addr=0, rom_rd_en=0, sample_o=0, sample_valid=0, busy=0, done=0, overrun=0, tick counter=0.
REQ-034 Reset asserted mid-playback SHALL discard all state; no done pulse SHALL be generated.

Verification (TICK_DIV=8, ROM[a]=a+0x100)
REQ-035 Bench SHALL cover: play at cycle 0, end_addr=3, loop_en=0, sample_ready=1 -> rd_en at cycles 1,9,17,25; samples 0x100..0x103; done at cycle 26; busy=0 at cycle 27.
REQ-036 Bench SHALL cover: loop_en=1, end_addr=1 -> address sequence 0,1,0,1,...; no done pulse; busy stays 1.
REQ-037 Bench SHALL cover: sample_ready=0 throughout -> overrun=1 after the second LATCH; sample_o=0x101; sample_valid=1.
REQ-038 Bench SHALL cover: stop in the READ cycle of fetch #2 -> IDLE next cycle; sample_o stays 0x100; done=0.
REQ-039 Bench SHALL cover: rst pulse during WAIT -> all outputs 0 immediately; a subsequent play restarts from address 0.
REQ-040 Bench SHALL cover: play held high continuously across completion -> a new playback starts on the cycle after IDLE is entered; play pulse while busy -> no effect.
